regfile_decoded_wr: RTL
=======================

Name: regfile_decoded_wr

Overview:
- Parametrised register file for the processor datapath. Successor to the fixed 5-to-32 write-enable decoder.
- Generalises depth and width and integrates the write decoder, which stays externally visible as a one-hot bus.
- Adds two combinational read ports and a per-register pending (scoreboard) bit, so issue logic can detect outstanding writes.

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers; any value from 2 to 2**ADDR_W
- ADDR_W, 5, address width of every address port
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never pending

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  write request
- wr_addr  input  ADDR_W  write register index
- wr_data  input  WIDTH  write data
- wr_onehot  output  DEPTH  decoded write strobe, bit i = accepted write to register i
- alloc_en  input  1  mark a register pending (destination of an in-flight result)
- alloc_addr  input  ADDR_W  register to mark pending
- rd_addr_a  input  ADDR_W  read port A index
- rd_data_a  output  WIDTH  read port A data
- rd_pend_a  output  1  pending flag of the register at rd_addr_a
- rd_addr_b  input  ADDR_W  read port B index
- rd_data_b  output  WIDTH  read port B data
- rd_pend_b  output  1  pending flag of the register at rd_addr_b

Behaviour:
- Reset: while rst is high, all registers are 0 and all pending bits are 0, asynchronously. wr_onehot is forced to 0 and writes and allocs are ignored. Read ports return 0 during reset.
- Write decode (combinational): wr_onehot[i] = wr_en & (wr_addr == i) & ~rst.
  - wr_addr >= DEPTH produces all zeros and no write.
  - With ZERO_REG=1, bit 0 is always 0.
  - At most one bit is set.
- Write: at posedge clk, the register selected by wr_onehot takes wr_data. Latency is 1 cycle; the new value is visible on the read ports the cycle after the edge.
- Read: rd_data_x = reg[rd_addr_x], combinational.
  - rd_addr_x >= DEPTH returns 0 with pending 0.
  - With ZERO_REG=1, address 0 returns 0 with pending 0.
- Same-cycle read of the address being written returns the old value, unless REGFILE_BYPASS_EN is defined.
- Pending bit per register, updated at posedge:
  - alloc only: set.
  - write only: clear.
  - alloc and write to the same address in the same cycle: the bit stays/becomes set (new allocation wins) and the data is still written.
  - alloc and write to different addresses: both take effect independently.
  - Out-of-range or ZERO_REG-protected addresses: ignored.
- rd_pend_x reflects the registered pending bit: visible the cycle after alloc, clear the cycle after the write edge.
- Reset asserted mid-operation: any write or alloc in that cycle is lost. After deassertion, the first rising edge performs normal operation.
- Ports A and B are fully independent; both may read the same address.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If wr_onehot is non-zero and rd_addr_x == wr_addr, then:
  - rd_data_x = wr_data in the same cycle;
  - rd_pend_x = 0, unless the same-cycle alloc targets that address.
  - The ZERO_REG and out-of-range rules still take precedence (they return 0).
- Undefined: no forwarding; reads show stored contents only, with 1-cycle write-to-read latency.

Test Plan:
- Decode sweep: wr_en=0 with wr_addr=0 -> wr_onehot=0. Then wr_en=1 and wr_addr stepped 1..31, one cycle each -> wr_onehot = 1<<addr. wr_addr=0 with ZERO_REG=1 -> wr_onehot=0.
- Write/read: write 0xDEADBEEF to r5, next cycle rd_addr_a=5 -> rd_data_a=0xDEADBEEF. Write 0x12345678 to r0, then read r0 -> 0.
- Same-cycle hazard: write 0xA5A5A5A5 to r7 while rd_addr_b=7 (r7 previously 0x1) -> rd_data_b=0x1 without the macro, 0xA5A5A5A5 with REGFILE_BYPASS_EN. Next cycle -> 0xA5A5A5A5 in both builds.
- Scoreboard:
  - alloc r9 -> next cycle rd_pend_a=1 at rd_addr_a=9;
  - write r9 -> next cycle rd_pend_a=0;
  - alloc r9 together with a write to r9 -> rd_pend_a=1 and data updated.
- Reset mid-operation: fill r1..r3 with 1,2,3 and alloc r4; assert rst between edges -> reads return 0 immediately, pending 0. A write issued during reset leaves r1=0 after release.
- Parametrisation: DEPTH=8, WIDTH=16 -> wr_addr=10 gives wr_onehot=0 and no write; rd_addr_a=10 returns 0. Write 0xBEEF to r7 then read -> 0xBEEF.

Source files
------------

// File: rtl/regfile_decoded_wr.sv
// Parametrised register file with an exposed one-hot write decoder, two
// combinational read ports and a per-register pending bit.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_decoded_wr #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [DEPTH-1:0]  wr_onehot,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic              rd_pend_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_pend_b
);

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [DEPTH-1:0]  alloc_hit;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_data [2];
  logic              rd_pend [2];

  // Out-of-range addresses match no index, so they decode to nothing.
  always_comb begin
    wr_onehot = '0;
    alloc_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
        wr_onehot[i] = wr_en & (wr_addr == ADDR_W'(i)) & ~rst;
        alloc_hit[i] = alloc_en & (alloc_addr == ADDR_W'(i)) & ~rst;
      end
    end
  end

  // A same-cycle alloc overrides the clear caused by the completing write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = wr_onehot[i] ? wr_data : regs_q[i];
      pend_d[i] = alloc_hit[i] | (pend_q[i] & ~wr_onehot[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      pend_q <= pend_d;
    end
  end

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_pend[p] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr[p] == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
          rd_data[p] = regs_q[i];
          rd_pend[p] = pend_q[i];
`ifdef REGFILE_BYPASS_EN
          if (wr_onehot[i]) begin
            rd_data[p] = wr_data;
            rd_pend[p] = alloc_hit[i];
          end
`endif
        end
      end
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_pend_a = rd_pend[0];
  assign rd_data_b = rd_data[1];
  assign rd_pend_b = rd_pend[1];

endmodule
